// File: rtl/mmnet_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mmnet_pkg : shared sizes, types and loader states for minimobilenet |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package mmnet_pkg;

  localparam int PX_SIZE         = 8;
  localparam int INPUT_SIZE      = 32;
  localparam int INPUT_CHANNELS  = 3;
  localparam int OUTPUT_CHANNELS = 10;
  localparam int CLASS_W         = $clog2(OUTPUT_CHANNELS);

  typedef logic signed [PX_SIZE-1:0] px_t;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    SCAN   = 2'd2,
    RESULT = 2'd3
  } load_state_e;

endpackage
`default_nettype wire

// File: rtl/argmax_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | argmax_seq : sequential signed argmax, one class compared per cycle |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module argmax_seq
  import mmnet_pkg::*;
#(
  parameter int N_CLASS = OUTPUT_CHANNELS,
  parameter int SCORE_W = PX_SIZE,
  parameter int IDX_W   = $clog2(N_CLASS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [N_CLASS*SCORE_W-1:0]   scores,
  output logic                         done,
  output logic [IDX_W-1:0]             idx,
  output logic signed [SCORE_W-1:0]    max
);

  localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(N_CLASS - 1);

  logic [N_CLASS*SCORE_W-1:0] score_buf;
  logic [IDX_W-1:0]           pos;
  logic                       busy;
  logic signed [SCORE_W-1:0]  cur;

  assign cur = score_buf[pos*SCORE_W +: SCORE_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      score_buf <= '0;
      pos       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      idx       <= '0;
      max       <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        score_buf <= scores;
        pos       <= '0;
        busy      <= 1'b1;
      end else if (busy) begin
        // First class seeds the running max; later ones replace it only when strictly greater.
        if (pos == '0 || cur > max) begin
          idx <= pos;
          max <= cur;
        end
        if (pos == LAST_POS) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          pos <= pos + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/img_stream_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | img_stream_loader : stream-to-tensor loader with settle + argmax    |
// | Optional macro IMG_LOADER_PERF_EN adds perf_cycles. Rev 1.0         |
// +--------------------------------------------------------------------+
module img_stream_loader #(
  parameter int INPUT_SIZE      = mmnet_pkg::INPUT_SIZE,
  parameter int INPUT_CHANNELS  = mmnet_pkg::INPUT_CHANNELS,
  parameter int PX_SIZE         = mmnet_pkg::PX_SIZE,
  parameter int OUTPUT_CHANNELS = mmnet_pkg::OUTPUT_CHANNELS,
  parameter int SETTLE_CYCLES   = 4
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                s_valid,
  output logic                                                s_ready,
  input  logic [PX_SIZE-1:0]                                  s_data,
  input  logic                                                s_last,
  output logic [INPUT_SIZE*INPUT_SIZE*INPUT_CHANNELS*PX_SIZE-1:0] img_out,
  input  logic [OUTPUT_CHANNELS*PX_SIZE-1:0]                  net_scores,
  output logic                                                res_valid,
  input  logic                                                res_ready,
  output logic [$clog2(OUTPUT_CHANNELS)-1:0]                  res_class,
  output logic [PX_SIZE-1:0]                                  res_score,
  output logic                                                err_len
`ifdef IMG_LOADER_PERF_EN
  ,
  output logic [31:0]                                         perf_cycles
`endif
);

  localparam int N_ELEM  = INPUT_SIZE * INPUT_SIZE * INPUT_CHANNELS;
  localparam int K_W     = $clog2(N_ELEM);
  localparam int SET_W   = $clog2(SETTLE_CYCLES + 1);
  localparam int CLASS_W = $clog2(OUTPUT_CHANNELS);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(N_ELEM - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

  mmnet_pkg::load_state_e state;
  logic [K_W-1:0]         k;
  logic [SET_W-1:0]       set_cnt;
  logic                   scan_start;
  logic                   scan_done;
  logic [CLASS_W-1:0]     scan_idx;
  logic signed [PX_SIZE-1:0] scan_max;
  logic                   in_hs;
  logic                   res_hs;

  assign in_hs  = (state == mmnet_pkg::LOAD) && s_valid && s_ready;
  assign res_hs = (state == mmnet_pkg::RESULT) && res_valid && res_ready;

  argmax_seq #(
    .N_CLASS (OUTPUT_CHANNELS),
    .SCORE_W (PX_SIZE),
    .IDX_W   (CLASS_W)
  ) u_argmax (
    .clk    (clk),
    .rst    (rst),
    .start  (scan_start),
    .scores (net_scores),
    .done   (scan_done),
    .idx    (scan_idx),
    .max    (scan_max)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= mmnet_pkg::LOAD;
      k          <= '0;
      set_cnt    <= '0;
      scan_start <= 1'b0;
      img_out    <= '0;
      s_ready    <= 1'b1;
      res_valid  <= 1'b0;
      res_class  <= '0;
      res_score  <= '0;
      err_len    <= 1'b0;
    end else begin
      err_len    <= 1'b0;
      scan_start <= 1'b0;
      case (state)
        mmnet_pkg::LOAD: begin
          if (in_hs) begin
            img_out[k*PX_SIZE +: PX_SIZE] <= s_data;
            if (s_last && k == K_LAST) begin
              state   <= mmnet_pkg::SETTLE;
              set_cnt <= '0;
              s_ready <= 1'b0;
              k       <= '0;
            end else if (s_last || k == K_LAST) begin
              // Length mismatch: drop the frame and wait for a fresh one.
              err_len <= 1'b1;
              k       <= '0;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        mmnet_pkg::SETTLE: begin
          if (set_cnt == SET_LAST) begin
            state      <= mmnet_pkg::SCAN;
            scan_start <= 1'b1;
          end else begin
            set_cnt <= set_cnt + 1'b1;
          end
        end
        mmnet_pkg::SCAN: begin
          if (scan_done) begin
            state     <= mmnet_pkg::RESULT;
            res_valid <= 1'b1;
            res_class <= scan_idx;
            res_score <= scan_max;
          end
        end
        mmnet_pkg::RESULT: begin
          if (res_hs) begin
            state     <= mmnet_pkg::LOAD;
            res_valid <= 1'b0;
            s_ready   <= 1'b1;
            k         <= '0;
          end
        end
        default: state <= mmnet_pkg::LOAD;
      endcase
    end
  end

`ifdef IMG_LOADER_PERF_EN
  logic [31:0] perf_cnt;
  logic        perf_run;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt    <= '0;
      perf_run    <= 1'b0;
      perf_cycles <= '0;
    end else begin
      // Element 0 of any frame (including a retry after a length error) restarts the span.
      if (in_hs && k == '0) begin
        perf_cnt <= 32'd1;
        perf_run <= 1'b1;
      end else if (perf_run) begin
        perf_cnt <= perf_cnt + 32'd1;
      end
      if (res_hs) begin
        perf_cycles <= perf_cnt + 32'd1;
        perf_run    <= 1'b0;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_img_stream_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_img_stream_loader : randomized self-checking bench, ref model    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_img_stream_loader;

  localparam int IS   = 32;
  localparam int IC   = 3;
  localparam int PX   = 8;
  localparam int OC   = 10;
  localparam int NT   = IS * IS * IC;
  localparam int LAT  = 1 + 4 + OC + 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic [PX-1:0]        s_data = '0;
  logic                 s_last = 1'b0;
  logic [NT*PX-1:0]     img_out;
  logic [OC*PX-1:0]     net_scores = '0;
  logic                 res_valid;
  logic                 res_ready = 1'b0;
  logic [3:0]           res_class;
  logic [PX-1:0]        res_score;
  logic                 err_len;
`ifdef IMG_LOADER_PERF_EN
  logic [31:0]          perf_cycles;
`endif

  img_stream_loader dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .img_out    (img_out),
    .net_scores (net_scores),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_class  (res_class),
    .res_score  (res_score),
    .err_len    (err_len)
`ifdef IMG_LOADER_PERF_EN
    ,
    .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  int          errs = 0;
  int          checks = 0;
  int          cyc = 0;
  int          err_pulses = 0;
  int          hs_cyc = 0;
  int          first_cyc = 0;
  logic [PX-1:0] fdata [NT];
  logic [PX-1:0] sc [OC];
  logic [NT*PX-1:0] exp_img;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (err_len) err_pulses <= err_pulses + 1;
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference argmax: find the largest signed value, then the lowest index holding it.
  function automatic void ref_argmax(output int ci, output logic [PX-1:0] cs);
    int best;
    best = -1000;
    for (int i = 0; i < OC; i++)
      if (int'($signed(sc[i])) > best) best = int'($signed(sc[i]));
    ci = -1;
    for (int i = OC - 1; i >= 0; i--)
      if (int'($signed(sc[i])) == best) ci = i;
    cs = PX'(best);
  endfunction

  task automatic drive_scores();
    for (int i = 0; i < OC; i++) net_scores[i*PX +: PX] = sc[i];
  endtask

  task automatic send_frame(input int len, input bit gaps);
    int n;
    for (int k = 0; k < len; k++) begin
      if (gaps) begin
        while ($urandom % 2 == 0) begin
          s_valid = 1'b0;
          tick();
        end
      end
      s_valid = 1'b1;
      s_data  = fdata[k];
      s_last  = (k == len - 1);
      n = 0;
      while (!s_ready && n < 100) begin
        tick();
        n++;
      end
      if (!s_ready) chk_eq("ready_timeout", 0, 1);
      tick();
      if (k == 0) first_cyc = cyc;
      hs_cyc = cyc;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic run_frame(input string nm, input bit gaps, input int hold);
    int n;
    int ci;
    logic [PX-1:0] cs;
    bit ok;
    bit stable;
    drive_scores();
    for (int k = 0; k < NT; k++) exp_img[k*PX +: PX] = fdata[k];
    ref_argmax(ci, cs);
    send_frame(NT, gaps);
    n = 0;
    ok = 1'b1;
    while (!res_valid && n < 64) begin
      if (s_ready) ok = 1'b0;
      tick();
      n++;
    end
    chk_eq({nm, "_latency"}, 64'(cyc - hs_cyc), 64'(LAT));
    chk_eq({nm, "_sready_busy"}, {63'd0, ok}, 1);
    chk_eq({nm, "_class"}, 64'(res_class), 64'(ci));
    chk_eq({nm, "_score"}, 64'(res_score), 64'(cs));
    chk_eq({nm, "_img"}, {63'd0, img_out == exp_img}, 1);
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (!res_valid || res_class != 4'(ci) || res_score != cs || s_ready) stable = 1'b0;
    end
    if (hold > 0) chk_eq({nm, "_hold_stable"}, {63'd0, stable}, 1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
`ifdef IMG_LOADER_PERF_EN
    chk_eq({nm, "_perf"}, 64'(perf_cycles), 64'(cyc - first_cyc + 1));
`endif
    chk_eq({nm, "_after_hs_valid"}, {63'd0, res_valid}, 0);
    chk_eq({nm, "_after_hs_ready"}, {63'd0, s_ready}, 1);
  endtask

  task automatic rand_data();
    for (int k = 0; k < NT; k++) fdata[k] = PX'($urandom);
  endtask

  task automatic rand_scores(input bit narrow);
    for (int i = 0; i < OC; i++) sc[i] = narrow ? PX'($urandom_range(3, 0)) : PX'($urandom);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk_eq({nm, "_sready"}, {63'd0, s_ready}, 1);
    chk_eq({nm, "_rvalid"}, {63'd0, res_valid}, 0);
    chk_eq({nm, "_rclass"}, 64'(res_class), 0);
    chk_eq({nm, "_rscore"}, 64'(res_score), 0);
    chk_eq({nm, "_errlen"}, {63'd0, err_len}, 0);
    chk_eq({nm, "_img_zero"}, {63'd0, img_out == '0}, 1);
`ifdef IMG_LOADER_PERF_EN
    chk_eq({nm, "_perf"}, 64'(perf_cycles), 0);
`endif
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    bit quiet;
    logic [PX-1:0] t;
    logic [PX-1:0] sa [OC];
    repeat (3) tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    // Directed frame: element k carries k[7:0].
    for (int k = 0; k < NT; k++) fdata[k] = PX'(k);
    sa = '{8'd5, 8'hFD, 8'd20, 8'd7, 8'd20, 8'd0, 8'd0, 8'd0, 8'd0, 8'h80};
    sc = sa;
    run_frame("directed", 1'b0, 0);

    // Corner slots of the directed frame, re-sent and checked before the handshake.
    drive_scores();
    send_frame(NT, 1'b0);
    t = img_out[0 +: PX];
    chk_eq("slot_first", 64'(t), 0);
    t = img_out[(NT-1)*PX +: PX];
    chk_eq("slot_last", 64'(t), 64'hFF);
    repeat (LAT + 2) tick();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // Early s_last at k=100, then a good random frame.
    p0 = err_pulses;
    rand_data();
    send_frame(101, 1'b0);
    tick();
    chk_eq("early_err_pulses", 64'(err_pulses - p0), 1);
    chk_eq("early_still_loading", {63'd0, s_ready}, 1);
    rand_data();
    rand_scores(1'b0);
    run_frame("after_err", 1'b0, 0);

    // All scores at the minimum: tie resolves to class 0.
    for (int i = 0; i < OC; i++) sc[i] = 8'h80;
    rand_data();
    run_frame("all_min", 1'b0, 0);

    // Consumer stalls 50 cycles in RESULT.
    rand_data();
    rand_scores(1'b1);
    run_frame("stall", 1'b0, 50);

    // Reset in the middle of the scan.
    rand_data();
    rand_scores(1'b0);
    drive_scores();
    send_frame(NT, 1'b0);
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("mid_scan_rst");
    quiet = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (res_valid) quiet = 1'b0;
    end
    chk_eq("mid_scan_no_result", {63'd0, quiet}, 1);
    rand_data();
    rand_scores(1'b1);
    run_frame("post_rst", 1'b0, 0);

    // Gapped stream of the directed data must build the same tensor.
    for (int k = 0; k < NT; k++) fdata[k] = PX'(k);
    rand_scores(1'b0);
    run_frame("gapped", 1'b1, 0);

    // A couple of extra random frames with narrow scores to force ties.
    for (int r = 0; r < 2; r++) begin
      rand_data();
      rand_scores(1'b1);
      run_frame($sformatf("rand%0d", r), (r == 1), 3);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/img_stream_loader.md
Name: img_stream_loader

Overview:
- Front/back-end adapter for minimobilenet. Accepts one image as a pixel stream over valid/ready and assembles it into the packed tensor the network consumes.
- Holds the tensor stable for a fixed number of settle cycles while the network evaluates.
- Scans the OUTPUT_CHANNELS class scores sequentially for an argmax and returns the result over a valid/ready result port.
- Sits between the DMA/test stream and the combinational network.

Parameters:
- INPUT_SIZE, 32, image height = width
- INPUT_CHANNELS, 3, channels per pixel
- PX_SIZE, 8, bits per element (signed two's complement)
- OUTPUT_CHANNELS, 10, number of class scores
- SETTLE_CYCLES, 4, cycles the tensor is held before scores are sampled (min 1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_valid  in  1  stream element valid
- s_ready  out  1  loader can accept an element
- s_data  in  PX_SIZE  stream element
- s_last  in  1  marks final element of the frame
- img_out  out  INPUT_SIZE*INPUT_SIZE*INPUT_CHANNELS*PX_SIZE  packed tensor to network, indexed [row][col][ch][bit]
- net_scores  in  OUTPUT_CHANNELS*PX_SIZE  network output, [class][bit]
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_class  out  $clog2(OUTPUT_CHANNELS)  argmax index
- res_score  out  PX_SIZE  winning score
- err_len  out  1  one-cycle pulse: frame length mismatch

Behaviour:
- Reset: state LOAD, element counter 0, img_out all 0, s_ready 1, res_valid 0, res_class 0, res_score 0, err_len 0. Reset mid-frame or mid-result discards everything; no partial result is emitted.
- Element order: channel fastest, then column, then row. Element k maps to row = k/(INPUT_SIZE*INPUT_CHANNELS), col = (k/INPUT_CHANNELS)%INPUT_SIZE, ch = k%INPUT_CHANNELS. N = INPUT_SIZE^2*INPUT_CHANNELS.
- LOAD: s_ready=1. On s_valid&&s_ready, write s_data to slot k and increment k.
  - Transfer with k==N-1 and s_last=1: go to SETTLE, settle counter = 0.
  - s_last=1 with k<N-1, or s_last=0 with k==N-1: pulse err_len, reset k to 0, stay in LOAD. img_out contents are don't-care until the next good frame.
- SETTLE: s_ready=0, img_out frozen. Counter increments each cycle. After SETTLE_CYCLES cycles, go to SCAN.
- SCAN: net_scores is registered once into a score buffer on entry. One class is compared per cycle, index 0..OUTPUT_CHANNELS-1.
  - Signed compare; the running max is replaced only on strictly greater, so ties resolve to the lowest index.
  - Takes OUTPUT_CHANNELS cycles, then go to RESULT.
- RESULT: res_valid=1; res_class and res_score stable while res_valid && !res_ready. On handshake: res_valid to 0, k to 0, go to LOAD.
- s_ready=0 in SETTLE, SCAN and RESULT. There is no input buffering across frames.
- Latency from the last input handshake to res_valid = 1 + SETTLE_CYCLES + OUTPUT_CHANNELS + 1 cycles; with defaults this is 16.
- res_valid never drops without a handshake except on rst.

Optional Feature:
- Macro: IMG_LOADER_PERF_EN.
- Defined: adds output perf_cycles[31:0]. It counts cycles from the first accepted element of a frame to the result handshake, inclusive. It is latched at the handshake, holds until the next handshake, and is 0 on reset.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mmnet_pkg:
  - PX_SIZE, INPUT_SIZE, INPUT_CHANNELS, OUTPUT_CHANNELS defaults
  - px_t typedef (signed [PX_SIZE-1:0])
  - loader state enum {LOAD, SETTLE, SCAN, RESULT}
  - CLASS_W = $clog2(OUTPUT_CHANNELS)
- One sub-module: argmax_seq, the sequential signed argmax over a registered score vector. Interface is start / done / idx / max.

Test Plan:
- Full frame where element k = k[7:0], s_last on k=3071, scores {5,-3,20,7,20,0,0,0,0,-128} -> img_out[0][0][0]=0, img_out[31][31][2]=0xFF (k=3071); res_class=2, res_score=20; res_valid 16 cycles after the last handshake.
- Early s_last at k=100 -> err_len pulses once; the next full frame is accepted normally and gives the correct result.
- All scores -128 -> res_class=0, res_score=-128 (ties resolve to the lowest index).
- res_ready held low 50 cycles in RESULT -> res_valid, res_class, res_score stable; s_ready=0 throughout; after the handshake s_ready=1 the next cycle.
- rst asserted during SCAN -> the next cycle all outputs are at reset values; no res_valid; a new frame loads correctly.
- Random s_valid gaps (50% duty) over a full frame -> identical img_out to the gap-free run; with IMG_LOADER_PERF_EN, perf_cycles equals the measured span.
